// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
//   Shared definitions for the FIR control / delay-line stage: filter length,
//   address width, default sample width, controller state encoding and the
//   circular delay-line read-address helper.
package fir_ctrl_pkg;

  localparam int TAPS         = 8;
  localparam int ADDR_W       = $clog2(TAPS);
  localparam int DATA_W_DEF   = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Tap k of the current frame lives k slots behind the newest sample.
  // TAPS is a power of two, so the subtraction wraps naturally in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] tap_rd_addr(
    input logic [ADDR_W-1:0] wr_ptr,
    input logic [ADDR_W-1:0] k
  );
    return wr_ptr - k;
  endfunction

endpackage

// File: rtl/fir_ctrl_sample_ram.sv
// sample_ram
//   TAPS x DATA_W register file holding the FIR delay line.
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - asynchronous active-low clear of every word and the read register
//     i_we     - write enable
//     i_waddr  - write address
//     i_wdata  - write data
//     i_re     - read enable (updates the registered read port)
//     i_raddr  - read address
//     o_rdata  - registered read data
module sample_ram
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [TAPS];
  logic [DATA_W-1:0] r_rdata_p0;

  // Clearing the words on reset makes pre-history read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
      r_rdata_p0 <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata_p0 <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata_p0;

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl
//   Control and delay-line stage feeding the FIR mac. Accepts one sample per
//   frame over valid/ready, stores it in a circular delay line, then walks the
//   TAPS coefficient/sample pairs, emitting mac_init aligned with tap 0 data.
//   Ports:
//     clock    - sole clock, rising edge
//     reset    - asynchronous active-low reset
//     x_in     - input sample
//     valid_in - x_in is valid
//     ready_in - block can accept a sample (registered)
//     rom_addr - coefficient index to the external synchronous ROM
//     ram_out  - delayed sample x[n-k], registered, aligned with ROM data
//     mac_init - registered; 1 = mac loads the product instead of accumulating
//     busy     - high while a frame is being sequenced
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] ram_out,
  output logic              mac_init,
  output logic              busy
);

  state_t            r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_k,        w_k_nxt;
  logic [ADDR_W-1:0] r_wr_ptr,   w_wr_ptr_nxt;
  logic              r_ready,    w_ready_nxt;
  logic              r_mac_init, w_mac_init_nxt;
  logic              w_we;
  logic              w_re;
  logic              w_last;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_last    = (r_k == ADDR_W'(TAPS - 1));
  assign w_rd_addr = tap_rd_addr(r_wr_ptr, r_k);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_ready_nxt    = r_ready;
    w_mac_init_nxt = r_mac_init;
    w_we           = 1'b0;
    w_re           = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Holding mac_init high keeps the downstream mac cleared between frames.
        w_mac_init_nxt = 1'b1;
        if (valid_in && r_ready) begin
          w_we        = 1'b1;
          w_k_nxt     = '0;
          w_ready_nxt = 1'b0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_re           = 1'b1;
        // Registered together with ram_out so it lands on the tap-0 data cycle.
        w_mac_init_nxt = (r_k == '0);
        w_k_nxt        = r_k + 1'b1;
        if (w_last) begin
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          w_ready_nxt  = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_k        <= '0;
      r_wr_ptr   <= '0;
      r_ready    <= 1'b1;
      r_mac_init <= 1'b1;
    end else begin
      r_k        <= w_k_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_ready    <= w_ready_nxt;
      r_mac_init <= w_mac_init_nxt;
    end
  end

  // Address stage -> registered read stage (aligned with the ROM's sync read)
  sample_ram #(
    .DATA_W (DATA_W)
  ) u_sample_ram (
    .clk     (clock),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (x_in),
    .i_re    (w_re),
    .i_raddr (w_rd_addr),
    .o_rdata (ram_out)
  );

  assign ready_in = r_ready;
  assign rom_addr = r_k;
  assign mac_init = r_mac_init;
  assign busy     = (r_state == S_RUN);

endmodule

// File: tb/tb_fir_ctrl.sv
module tb_fir_ctrl;

  localparam int TAPS = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] x_in;
  logic       valid_in;
  logic       ready_in;
  logic [2:0] rom_addr;
  logic [7:0] ram_out;
  logic       mac_init;
  logic       busy;

  fir_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .x_in     (x_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .rom_addr (rom_addr),
    .ram_out  (ram_out),
    .mac_init (mac_init),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // External coefficient ROM with synchronous read.
  logic signed [7:0] rom [TAPS];
  logic signed [7:0] rom_q;
  always @(posedge clock) rom_q <= rom[rom_addr];

  int  errors = 0;
  int  checks = 0;
  int  hist[$];
  time last_t;
  bit  have_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Sample that should appear at tap k: k samples back, zero before history.
  function automatic int tap_val(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return 0;
  endfunction

  function automatic int ref_y();
    int s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += int'(rom[k]) * tap_val(k);
    return s;
  endfunction

  // One frame: offer x, check accept timing, every tap, and the mac-style sum.
  task automatic frame(input logic [7:0] x, input bit keep, input logic [7:0] nx, output int y);
    int w;
    int acc;
    int prod;
    w = 0;
    valid_in = 1'b1;
    x_in     = x;
    while (ready_in !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk("accept_ready", 32'(ready_in), 32'd1);
    @(posedge clock);
    if (have_last) chk("accept_spacing", 32'($time - last_t), 32'd90);
    last_t    = $time;
    have_last = 1'b1;
    hist.push_back(int'($signed(x)));
    @(negedge clock);
    if (keep) x_in = nx;
    else      valid_in = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_ready", 32'(ready_in), 32'd0);
    chk("run_addr0", 32'(rom_addr), 32'd0);
    chk("run_init_hold", 32'(mac_init), 32'd1);
    acc = 0;
    for (int j = 1; j <= TAPS; j++) begin
      @(negedge clock);
      chk($sformatf("tap%0d_data", j - 1), 32'(ram_out), 32'(tap_val(j - 1)) & 32'hFF);
      chk($sformatf("tap%0d_init", j - 1), 32'(mac_init), (j == 1) ? 32'd1 : 32'd0);
      if (j < TAPS) begin
        chk("tap_addr", 32'(rom_addr), 32'(j));
        chk("tap_busy", 32'(busy), 32'd1);
        chk("tap_ready", 32'(ready_in), 32'd0);
      end else begin
        chk("end_ready", 32'(ready_in), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_addr", 32'(rom_addr), 32'd0);
      end
      prod = int'($signed(ram_out)) * int'(rom_q);
      if (mac_init) acc = prod;
      else          acc += prod;
    end
    chk("frame_y", 32'(acc), 32'(ref_y()));
    y = acc;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    hist.delete();
    have_last = 1'b0;
  endtask

  initial begin
    int y;
    logic [7:0] xs [13];
    bit keep;
    logic [7:0] r;

    // Reset held with valid_in high: nothing may be accepted.
    reset = 1'b0; valid_in = 1'b1; x_in = 8'd5;
    for (int k = 0; k < TAPS; k++) rom[k] = 8'(k + 1);
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(ready_in), 32'd1);
    chk("rst_init", 32'(mac_init), 32'd1);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_ram", 32'(ram_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    frame(8'd5, 1'b0, 8'd0, y);
    chk("first_tap0_y", 32'(y), 32'd5);
    @(negedge clock);
    chk("idle_init_back", 32'(mac_init), 32'd1);
    chk("idle_ready", 32'(ready_in), 32'd1);

    // Impulse with ROM 1..8.
    pulse_reset();
    for (int f = 0; f < TAPS; f++) begin
      frame((f == 0) ? 8'd1 : 8'd0, 1'b0, 8'd0, y);
      chk($sformatf("impulse_y%0d", f), 32'(y), 32'(f + 1));
    end

    // Wrap-around, with the next sample held valid during RUN.
    pulse_reset();
    for (int i = 1; i <= 10; i++) frame(8'(i), (i < 10), 8'(i + 1), y);
    chk("wrap_tap0", 32'(hist[hist.size() - 1]), 32'd10);

    // Alignment: all-ones coefficients, constant input 2.
    for (int k = 0; k < TAPS; k++) rom[k] = 8'sd1;
    pulse_reset();
    for (int i = 0; i < TAPS; i++) frame(8'd2, 1'b1, 8'd2, y);
    chk("align_steady", 32'(y), 32'd16);
    frame(8'd2, 1'b0, 8'd0, y);
    chk("align_steady2", 32'(y), 32'd16);

    // Randomized samples and coefficients.
    for (int k = 0; k < TAPS; k++) rom[k] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 13; i++) xs[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 12; i++) begin
      keep = 1'($urandom_range(0, 1));
      frame(xs[i], keep, xs[i + 1], y);
    end

    // Reset in the middle of a frame at tap 4.
    r = 8'($urandom_range(1, 255));
    valid_in = 1'b1; x_in = r;
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_in), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_init", 32'(mac_init), 32'd1);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_ram", 32'(ram_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    hist.delete();
    have_last = 1'b0;
    r = 8'($urandom_range(1, 255));
    frame(r, 1'b0, 8'd0, y);
    chk("post_rst_y", 32'(y), 32'(int'($signed(r)) * int'(rom[0])));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
